// File: rtl/quarter_wave_dds_pkg.sv
// Shared definitions for the quarter-wave DDS: waveform select codes and
// quadrant numbering of the phase accumulator's top two bits.
package quarter_wave_dds_pkg;

    typedef enum logic [1:0] {
        MODE_SINE   = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_SAW    = 2'd3
    } mode_e;

    localparam logic [1:0] Q1 = 2'd0;
    localparam logic [1:0] Q2 = 2'd1;
    localparam logic [1:0] Q3 = 2'd2;
    localparam logic [1:0] Q4 = 2'd3;

endpackage

// File: rtl/quarter_wave_dds_if.sv
// Control, ROM and sample-output bundle of the DDS. The slave side is the
// generator; the master side is the register block, ROM and DAC stage.
interface quarter_wave_dds_if #(
    parameter int PHASE_W = 16,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8
);
    logic               en;
    logic [PHASE_W-1:0] ftw;
    logic               ftw_load;
    logic               phase_clr;
    logic [1:0]         mode;
    logic [ADDR_W-1:0]  lut_addr;
    logic [DATA_W-1:0]  lut_data;
    logic [DATA_W:0]    sample;
    logic               sample_valid;
    logic [1:0]         quadrant;

    modport master (
        output en, ftw, ftw_load, phase_clr, mode, lut_data,
        input  lut_addr, sample, sample_valid, quadrant
    );

    modport slave (
        input  en, ftw, ftw_load, phase_clr, mode, lut_data,
        output lut_addr, sample, sample_valid, quadrant
    );
endinterface

// File: rtl/quarter_wave_dds_phase_accumulator.sv
// Phase accumulator with a latched tuning word; the load takes effect on the
// add one edge later, so a simultaneous load and advance uses the old word.
module phase_accumulator #(
    parameter int PHASE_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               phase_clr,
    input  logic               ftw_load,
    input  logic [PHASE_W-1:0] ftw,
    output logic [PHASE_W-1:0] acc
);

    logic [PHASE_W-1:0] ftw_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            ftw_q <= '0;
        end else begin
            if (phase_clr) begin
                acc <= '0;
            end else if (en) begin
                acc <= acc + ftw_q;
            end
            if (ftw_load) begin
                ftw_q <= ftw;
            end
        end
    end

endmodule

// File: rtl/quarter_wave_dds.sv
// Quarter-wave DDS: accumulator, address fold, external ROM read and
// sign/shape restoration, three registered stages from phase to sample.
module quarter_wave_dds
    import quarter_wave_dds_pkg::*;
#(
    parameter int PHASE_W = 16,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8
) (
    input logic              clk,
    input logic              rst_n,
    quarter_wave_dds_if.slave bus
);

    // PHASE_W must cover ADDR_W+2 (fold) and DATA_W+1 (sawtooth) bits.
    localparam logic [DATA_W:0] FULL_SCALE = {1'b0, {DATA_W{1'b1}}};

    logic [PHASE_W-1:0] acc;

    phase_accumulator #(.PHASE_W(PHASE_W)) u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (bus.en),
        .phase_clr (bus.phase_clr),
        .ftw_load  (bus.ftw_load),
        .ftw       (bus.ftw),
        .acc       (acc)
    );

    logic [1:0]        acc_q;
    logic [ADDR_W-1:0] acc_idx;
    assign acc_q   = acc[PHASE_W-1 -: 2];
    assign acc_idx = acc[PHASE_W-3 -: ADDR_W];

    logic [ADDR_W-1:0] lut_addr_r;
    logic [1:0]        s1_q;
    mode_e             s1_mode;
    logic [DATA_W:0]   s1_saw;
    logic              s1_valid;

    // Stage 1: odd quadrants run the table backwards, so fold the index there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lut_addr_r <= '0;
            s1_q       <= '0;
            s1_mode    <= MODE_SINE;
            s1_saw     <= '0;
            s1_valid   <= 1'b0;
        end else begin
            lut_addr_r <= acc_q[0] ? ~acc_idx : acc_idx;
            s1_q       <= acc_q;
            s1_mode    <= mode_e'(bus.mode);
            s1_saw     <= acc[PHASE_W-1 -: DATA_W+1];
            s1_valid   <= bus.en;
        end
    end

    logic [ADDR_W-1:0] s2_addr;
    logic [1:0]        s2_q;
    mode_e             s2_mode;
    logic [DATA_W:0]   s2_saw;
    logic              s2_valid;

    // Stage 2: wait out the ROM's read cycle with the sample's side info.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_addr  <= '0;
            s2_q     <= '0;
            s2_mode  <= MODE_SINE;
            s2_saw   <= '0;
            s2_valid <= 1'b0;
        end else begin
            s2_addr  <= lut_addr_r;
            s2_q     <= s1_q;
            s2_mode  <= s1_mode;
            s2_saw   <= s1_saw;
            s2_valid <= s1_valid;
        end
    end

    logic [ADDR_W+DATA_W-1:0] tri_pad;
    logic [DATA_W:0]          tri_ext;
    logic [DATA_W:0]          sine_ext;
    logic                     negative;
    logic [DATA_W:0]          next_sample;

    assign tri_pad  = {s2_addr, {DATA_W{1'b0}}};
    assign tri_ext  = {1'b0, tri_pad[ADDR_W+DATA_W-1 -: DATA_W]};
    assign sine_ext = {1'b0, bus.lut_data};
    assign negative = (s2_q == Q3) || (s2_q == Q4);

    // Stage 3 shaping: the lower half-period is the upper half negated.
    always_comb begin
        next_sample = '0;
        unique case (s2_mode)
            MODE_SINE:   next_sample = negative ? -sine_ext   : sine_ext;
            MODE_SQUARE: next_sample = negative ? -FULL_SCALE : FULL_SCALE;
            MODE_TRI:    next_sample = negative ? -tri_ext    : tri_ext;
            MODE_SAW:    next_sample = {~s2_saw[DATA_W], s2_saw[DATA_W-1:0]};
            default:     next_sample = '0;
        endcase
    end

    logic [DATA_W:0] sample_r;
    logic [1:0]      quadrant_r;
    logic            valid_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_r   <= '0;
            quadrant_r <= '0;
            valid_r    <= 1'b0;
        end else begin
            sample_r   <= next_sample;
            quadrant_r <= s2_q;
            valid_r    <= s2_valid;
        end
    end

    assign bus.lut_addr     = lut_addr_r;
    assign bus.sample       = sample_r;
    assign bus.quadrant     = quadrant_r;
    assign bus.sample_valid = valid_r;

endmodule

// File: doc/quarter_wave_dds.md
# quarter_wave_dds

Parametrised direct-digital-synthesis waveform generator. A phase accumulator with a programmable frequency tuning word drives a quarter-wave magnitude ROM through address folding and sign restoration. It produces signed sine, square, triangle or sawtooth samples behind a 3-cycle pipeline with a valid strobe. It sits between the control registers and the DAC/PWM output stage, and supersedes the fixed 4-state quadrant controller.

## Interface
- `PHASE_W`, 16: accumulator width. Must satisfy `PHASE_W >= ADDR_W+2`.
- `ADDR_W`, 6: quarter-wave ROM address width (2^ADDR_W entries).
- `DATA_W`, 8: unsigned ROM magnitude width.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: accumulator advance enable.
- `ftw`  in  PHASE_W: frequency tuning word, sampled on `ftw_load`.
- `ftw_load`  in  1: latch `ftw` into the internal `ftw_q` register.
- `phase_clr`  in  1: synchronous clear of the accumulator.
- `mode`  in  2: waveform select.
  - 0 sine.
  - 1 square.
  - 2 triangle.
  - 3 sawtooth.
- `lut_addr`  out  ADDR_W: address to the external synchronous ROM (1-cycle read).
- `lut_data`  in  DATA_W: ROM magnitude, valid one cycle after `lut_addr`.
- `sample`  out  DATA_W+1: signed two's-complement output sample.
- `sample_valid`  out  1: `sample` is a new sample.
- `quadrant`  out  2: quadrant of the sample currently on `sample`.

## Operation
- Reset (async, `rst_n`=0) clears every register to 0:
  - `acc`, `ftw_q`, `lut_addr`, `sample`, `sample_valid`, `quadrant`, and all pipeline registers.
- Stage 0, accumulator:
  - `phase_clr` → `acc` <= 0. It has priority over `en`.
  - Otherwise, `en` → `acc` <= `acc + ftw_q` (mod 2^PHASE_W, wrap silently).
  - Otherwise `acc` holds.
- `ftw_load` → `ftw_q` <= `ftw`. The new word is first used in the add on the following edge. Simultaneous `ftw_load` and `en` add the old `ftw_q`.
- Field split of `acc`:
  - `q` = `acc[PHASE_W-1:PHASE_W-2]`.
  - `idx` = `acc[PHASE_W-3:PHASE_W-2-ADDR_W]`.
  - Lower bits are fractional and are ignored by the output path.
- Stage 1, fold (registered):
  - `lut_addr` = `q[0]` ? `~idx` : `idx`.
  - `q` is registered alongside; `mode` is registered here too.
- Stage 2, ROM read: `lut_data` returns; `q` and `mode` are delayed one more cycle.
- Stage 3, output (registered):
  - Sine: `sample` = `q[1]` ? −{0,`lut_data`} : {0,`lut_data`}.
  - Square: `sample` = `q[1]` ? −(2^DATA_W−1) : +(2^DATA_W−1).
  - Triangle: magnitude = {`q[0]`? `~idx`:`idx`, zero-pad to DATA_W}, using the stage-2-aligned `idx`. The sign is applied as for sine.
  - Sawtooth: `sample` = top DATA_W+1 bits of the aligned phase, MSB inverted so phase 0 maps to the most negative value.
- `quadrant` tracks the stage-3 `q`.
- `sample_valid`:
  - It is `en` delayed 3 cycles.
  - `phase_clr` does not suppress valid.
  - With `en` low the output pipeline keeps flushing, but `sample_valid` is 0 for those slots.
- Mode changes take effect on the sample whose phase entered stage 1 after the change. There is no glitch within a sample.

## Timing
- Latency: the phase held in `acc` at edge N appears on `sample` at edge N+3.
- Throughput: one sample per clock while `en`=1.
- Quadrant wrap, e.g. `q` 01→10, needs no extra cycle and stalls nothing. Accumulator overflow is treated identically.
- Reset asserted mid-stream: outputs go to 0 immediately (async). After release, the first valid sample is edge 3 of `en`=1.
- `ftw_q`=0 with `en`=1: `sample` is constant and `sample_valid` stays 1.

## Structure
- Shared package holds:
  - Mode encodings `MODE_SINE`, `MODE_SQUARE`, `MODE_TRI`, `MODE_SAW`.
  - Quadrant constants `Q1`..`Q4`.
- One natural sub-module: `phase_accumulator`, covering `acc`, `ftw_q`, `phase_clr` and `en`.
- Fold, pipeline and output logic stay in the top.
- The ROM stays external and is not instantiated here.

## Test plan
- Reset, then `ftw`=0x0100 loaded, `en`=1, sine mode, and a ROM model returning addr×4:
  - `lut_addr` counts 0..63, then 63..0.
  - `sample` is positive for quadrants 0–1 and negative for quadrants 2–3.
  - The period is 256 valid samples.
- Latency check: `phase_clr` pulse with `ftw`=0x0100, `en`=1. The sample for phase 0 appears exactly 3 cycles after `acc`=0. `sample` = 0, `quadrant`=0.
- `ftw_load` of 0x0200 mid-run: the `acc` step changes from 0x0100 to 0x0200 on the second edge after load, and `lut_addr` advances by 2 per cycle.
- Square mode, `ftw`=0x4000:
  - `sample` alternates +255,+255,−255,−255.
  - `quadrant` steps 0,1,2,3.
- `en` toggled 1,0,0,1: `acc` holds during low cycles, and `sample_valid` shows the same 1,0,0,1 pattern delayed 3 cycles.
- `rst_n` asserted mid-stream: all outputs are 0 within the same cycle, and `sample_valid` stays 0 for 3 cycles after release.
